// File: rtl/gray_convert_arbiter.sv
// gray_convert_arbiter: round-robin arbiter feeding a shared two-stage
// Gray-to-binary conversion pipeline with channel tagging and backpressure.
module gray_convert_arbiter #(
    parameter int unsigned WIDTH  = 5,
    parameter int unsigned NUM_CH = 4,
    localparam int unsigned CHAN_W = $clog2(NUM_CH)
) (
    input  logic                    clock,
    input  logic                    sclr,
    input  logic [NUM_CH-1:0]       req_valid,
    input  logic [NUM_CH*WIDTH-1:0] req_gray,
    output logic [NUM_CH-1:0]       req_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_bin,
    output logic [CHAN_W-1:0]       out_chan,
    input  logic                    out_ready
);

    logic              adv;
    logic              grant_found;
    logic [CHAN_W-1:0] grant_idx;
    logic              accept;
    logic [WIDTH-1:0]  grant_gray;
    logic [CHAN_W-1:0] rr_next;

    logic [CHAN_W-1:0] rr_ptr;
    logic              s1_valid;
    logic [WIDTH-1:0]  s1_gray;
    logic [CHAN_W-1:0] s1_chan;
    logic [WIDTH-1:0]  bin_c;

    // Whole pipeline moves only when the output register is free or draining.
    assign adv = !out_valid || out_ready;

    // Round-robin search starting at rr_ptr, ascending with wrap.
    always_comb begin
        int unsigned idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int unsigned off = 0; off < NUM_CH; off++) begin
            idx = 32'(rr_ptr) + off;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!grant_found && req_valid[CHAN_W'(idx)]) begin
                grant_found = 1'b1;
                grant_idx   = CHAN_W'(idx);
            end
        end
    end

    // One-hot accept, suppressed during stall or reset.
    always_comb begin
        req_ready = '0;
        if (grant_found && adv && !sclr) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign accept     = grant_found && adv && !sclr;
    assign grant_gray = req_gray[32'(grant_idx) * WIDTH +: WIDTH];
    assign rr_next    = (grant_idx == CHAN_W'(NUM_CH - 1)) ? '0 : grant_idx + CHAN_W'(1);

    // Gray to binary: each bit is the XOR of all Gray bits at or above it.
    always_comb begin
        bin_c            = '0;
        bin_c[WIDTH-1]   = s1_gray[WIDTH-1];
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            bin_c[i] = bin_c[i+1] ^ s1_gray[i];
        end
    end

    // Arbitration stage, conversion stage and round-robin pointer.
    always_ff @(posedge clock) begin
        if (sclr) begin
            rr_ptr    <= '0;
            s1_valid  <= 1'b0;
            s1_gray   <= '0;
            s1_chan   <= '0;
            out_valid <= 1'b0;
            out_bin   <= '0;
            out_chan  <= '0;
        end else if (adv) begin
            out_valid <= s1_valid;
            out_bin   <= bin_c;
            out_chan  <= s1_chan;
            s1_valid  <= accept;
            if (accept) begin
                s1_gray <= grant_gray;
                s1_chan <= grant_idx;
                rr_ptr  <= rr_next;
            end
        end
    end

endmodule

// File: tb/tb_gray_convert_arbiter.sv
// Directed self-checking bench for gray_convert_arbiter (WIDTH=5, NUM_CH=4).
module tb_gray_convert_arbiter;

    logic        clock;
    logic        sclr;
    logic [3:0]  req_valid;
    logic [19:0] req_gray;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [4:0]  out_bin;
    logic [1:0]  out_chan;
    logic        out_ready;

    int total;
    int bad;

    gray_convert_arbiter #(.WIDTH(5), .NUM_CH(4)) dut (
        .clock     (clock),
        .sclr      (sclr),
        .req_valid (req_valid),
        .req_gray  (req_gray),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_bin   (out_bin),
        .out_chan  (out_chan),
        .out_ready (out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_gray(input int ch, input logic [4:0] v);
        req_gray[ch*5 +: 5] = v;
    endtask

    function automatic logic [3:0] oh(input int ch);
        logic [3:0] r;
        r = '0;
        r[ch] = 1'b1;
        return r;
    endfunction

    // binary results for the stream gray values 00011,00110,00111,01100
    logic [4:0] bin_tab [4];
    int         g3 [8];
    int         g4 [5];
    int         o4 [5];

    initial begin
        total = 0;
        bad   = 0;
        bin_tab = '{5'b00010, 5'b00100, 5'b00101, 5'b01000};
        g3 = '{2, 3, 0, 1, 2, 3, 0, 1};
        g4 = '{2, 3, 0, 1, 2};
        o4 = '{0, 1, 2, 3, 0};

        sclr      = 1'b1;
        req_valid = 4'b1111;
        req_gray  = '0;
        out_ready = 1'b1;
        #1;
        chk("rst_ready_forced", 32'(req_ready), 32'h0);
        cyc();
        cyc();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_bin", 32'(out_bin), 32'h0);
        chk("rst_out_chan", 32'(out_chan), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);

        // single request on ch0, two-cycle latency
        sclr      = 1'b0;
        req_valid = 4'b0001;
        set_gray(0, 5'b01101);
        #1;
        chk("t1_ready", 32'(req_ready), 32'(4'b0001));
        cyc();
        req_valid = 4'b0000;
        #1;
        chk("t1_valid_early", 32'(out_valid), 32'h0);
        cyc();
        chk("t1_valid", 32'(out_valid), 32'h1);
        chk("t1_bin", 32'(out_bin), 32'(5'b01001));
        chk("t1_chan", 32'(out_chan), 32'h0);
        cyc();
        chk("t1_drain", 32'(out_valid), 32'h0);

        // conversion boundaries on ch1, back-to-back grants
        req_valid = 4'b0010;
        set_gray(1, 5'b00000);
        #1;
        chk("t2_ready_a", 32'(req_ready), 32'(4'b0010));
        cyc();
        set_gray(1, 5'b10000);
        #1;
        chk("t2_ready_b", 32'(req_ready), 32'(4'b0010));
        cyc();
        chk("t2_bin_zero", 32'(out_bin), 32'h0);
        chk("t2_chan_a", 32'(out_chan), 32'h1);
        chk("t2_valid_a", 32'(out_valid), 32'h1);
        set_gray(1, 5'b00001);
        #1;
        chk("t2_ready_c", 32'(req_ready), 32'(4'b0010));
        cyc();
        chk("t2_bin_msb", 32'(out_bin), 32'(5'b11111));
        req_valid = 4'b0000;
        cyc();
        chk("t2_bin_lsb", 32'(out_bin), 32'(5'b00001));
        chk("t2_chan_c", 32'(out_chan), 32'h1);
        cyc();
        chk("t2_drain", 32'(out_valid), 32'h0);

        // all channels continuously valid; pointer starts at 2
        set_gray(0, 5'b00011);
        set_gray(1, 5'b00110);
        set_gray(2, 5'b00111);
        set_gray(3, 5'b01100);
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("t3_ready_%0d", k), 32'(req_ready), 32'(oh(g3[k])));
            if (k >= 2) begin
                chk($sformatf("t3_valid_%0d", k), 32'(out_valid), 32'h1);
                chk($sformatf("t3_chan_%0d", k), 32'(out_chan), 32'(g3[k-2]));
                chk($sformatf("t3_bin_%0d", k), 32'(out_bin), 32'(bin_tab[g3[k-2]]));
            end
            cyc();
        end

        // three-cycle stall with both stages full
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("t4_stall_ready_%0d", k), 32'(req_ready), 32'h0);
            chk($sformatf("t4_stall_valid_%0d", k), 32'(out_valid), 32'h1);
            chk($sformatf("t4_stall_chan_%0d", k), 32'(out_chan), 32'h0);
            chk($sformatf("t4_stall_bin_%0d", k), 32'(out_bin), 32'(bin_tab[0]));
            cyc();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("t4_ready_%0d", k), 32'(req_ready), 32'(oh(g4[k])));
            chk($sformatf("t4_chan_%0d", k), 32'(out_chan), 32'(o4[k]));
            chk($sformatf("t4_bin_%0d", k), 32'(out_bin), 32'(bin_tab[o4[k]]));
            cyc();
        end

        // reset with both stages full and pointer at 3
        sclr      = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("t6_ready_in_rst", 32'(req_ready), 32'h0);
        cyc();
        sclr      = 1'b0;
        req_valid = 4'b1010;
        #1;
        chk("t6_valid_after", 32'(out_valid), 32'h0);
        chk("t6_ready_lowest", 32'(req_ready), 32'(4'b0010));
        cyc();
        req_valid = 4'b0000;
        #1;
        chk("t6_no_stale", 32'(out_valid), 32'h0);
        cyc();
        chk("t6_out_valid", 32'(out_valid), 32'h1);
        chk("t6_out_chan", 32'(out_chan), 32'h1);
        cyc();

        // ch3 only, then ch2 only: pointer wraps to 0 then lands on 3
        req_valid = 4'b1000;
        #1;
        chk("t5_ready_ch3", 32'(req_ready), 32'(4'b1000));
        cyc();
        req_valid = 4'b0100;
        #1;
        chk("t5_ready_ch2", 32'(req_ready), 32'(4'b0100));
        cyc();
        chk("t5_chan_first", 32'(out_chan), 32'h3);
        chk("t5_bin_first", 32'(out_bin), 32'(bin_tab[3]));
        req_valid = 4'b1001;
        #1;
        chk("t5_ptr_at_3", 32'(req_ready), 32'(4'b1000));
        cyc();
        req_valid = 4'b0000;
        chk("t5_chan_second", 32'(out_chan), 32'h2);
        chk("t5_bin_second", 32'(out_bin), 32'(bin_tab[2]));
        cyc();
        chk("t5_chan_third", 32'(out_chan), 32'h3);
        cyc();
        chk("t5_drain", 32'(out_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
